sar_comparator_model: RTL and testbench

Synthesizable comparator/analog front-end emulator for the ADC project: it sits on the far side of the R2R and PWM ADC interfaces, watching the DAC code and PWM stream the converter drives out and returning the comparator bits the converter consumes. It models an analog input voltage as a digital target code, enforces a DAC settling delay before the R2R comparator output changes, and integrates the PWM stream over a fixed window to model the RC filter. It is used for on-board loopback self-test and as a bit-accurate stimulus source in top-level simulation, replacing hand-scripted comparator patterns.

---
 rtl/sar_comparator_model.sv | 138 +++++++++++++
 tb/tb_sar_comparator_model.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_comparator_model.sv
// Comparator / analog front-end emulator for the R2R and PWM ADC paths (loopback and stimulus).
// Optional LFSR dither on the emulated input is enabled by defining SAR_COMPARATOR_MODEL_NOISE_EN.
module sar_comparator_model #(
  parameter int CODE_WIDTH      = 8,
  parameter int SETTLE_CYCLES   = 6250,
  parameter int PWM_WINDOW_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [CODE_WIDTH-1:0] i_target_in,
  input  logic                  i_target_load,
  input  logic [CODE_WIDTH-1:0] i_dac_code,
  input  logic                  i_pwm_in,
  output logic                  o_comp_r2r,
  output logic                  o_comp_pwm,
  output logic                  o_settled,
  output logic                  o_pwm_sample_valid
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PWM_WINDOW_LOG2-1:0] WIN_ONE = PWM_WINDOW_LOG2'(1);

  typedef enum logic {
    ST_SETTLING,
    ST_SETTLED
  } settle_state_e;

  logic [CODE_WIDTH-1:0]    r_target_q;
  logic [CODE_WIDTH-1:0]    r_dac_q;
  logic [CNT_W-1:0]         r_cnt;
  settle_state_e            r_state;
  logic                     r_comp_r2r;
  logic [PWM_WINDOW_LOG2-1:0] r_win;
  logic [PWM_WINDOW_LOG2:0] r_high;
  logic                     r_comp_pwm;
  logic                     r_pwm_valid;

  logic [CODE_WIDTH-1:0]    w_target_eff;
  logic                     w_reload;
  logic [CNT_W-1:0]         w_cnt_next;
  settle_state_e            w_state_next;
  logic                     w_comp_r2r_next;
  logic                     w_win_last;
  logic [PWM_WINDOW_LOG2:0] w_duty;

`ifdef SAR_COMPARATOR_MODEL_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  always_comb begin
    w_target_eff = r_target_q;
    if ((r_lfsr[1:0] == 2'b00) && (r_target_q != '0)) begin
      w_target_eff = r_target_q - CODE_WIDTH'(1);
    end else if ((r_lfsr[1:0] == 2'b11) && (r_target_q != '1)) begin
      w_target_eff = r_target_q + CODE_WIDTH'(1);
    end
  end
`else
  assign w_target_eff = r_target_q;
`endif

  // Dither acts only on target_eff, so it can never cause a settle reload.
  assign w_reload = (i_dac_code != r_dac_q) ||
                    (i_target_load && (i_target_in != r_target_q));

  always_comb begin
    w_state_next    = ST_SETTLING;
    w_cnt_next      = r_cnt;
    w_comp_r2r_next = r_comp_r2r;
    if (w_reload) begin
      w_cnt_next = SETTLE_RELOAD;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end else begin
      w_state_next    = ST_SETTLED;
      w_comp_r2r_next = (w_target_eff >= r_dac_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_target_q <= '0;
      r_dac_q    <= '0;
      r_cnt      <= SETTLE_RELOAD;
      r_state    <= ST_SETTLING;
      r_comp_r2r <= 1'b0;
    end else begin
      if (i_target_load) begin
        r_target_q <= i_target_in;
      end
      r_dac_q    <= i_dac_code;
      r_cnt      <= w_cnt_next;
      r_state    <= w_state_next;
      r_comp_r2r <= w_comp_r2r_next;
    end
  end

  // Duty includes the current clock's sample, so an all-high window reaches 2^PWM_WINDOW_LOG2.
  assign w_win_last = &r_win;
  assign w_duty     = r_high + (PWM_WINDOW_LOG2 + 1)'(i_pwm_in);

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_win       <= '0;
      r_high      <= '0;
      r_comp_pwm  <= 1'b0;
      r_pwm_valid <= 1'b0;
    end else begin
      r_win <= r_win + WIN_ONE;
      if (w_win_last) begin
        r_high      <= '0;
        r_comp_pwm  <= ({1'b0, w_target_eff} >= w_duty);
        r_pwm_valid <= 1'b1;
      end else begin
        r_high      <= w_duty;
        r_pwm_valid <= 1'b0;
      end
    end
  end

  assign o_comp_r2r         = r_comp_r2r;
  assign o_comp_pwm         = r_comp_pwm;
  assign o_settled          = (r_state == ST_SETTLED);
  assign o_pwm_sample_valid = r_pwm_valid;

endmodule

// File: tb/tb_sar_comparator_model.sv
// Self-checking bench for sar_comparator_model: R2R settling/compare and PWM window integration
// checked against an abstract model (target >= dac after settle delay, target >= highs per window).
module tb_sar_comparator_model;

  localparam int CW   = 8;
  localparam int S    = 6250;
  localparam int WIN  = 256;
  localparam int HOLD = 6300;

  localparam logic [7:0] SAR_SEQ [8] = '{8'h80, 8'hC0, 8'hE0, 8'hD0, 8'hD8, 8'hD4, 8'hD2, 8'hD3};
  localparam logic [7:0] SAR_BITS = 8'b1101_0010;
  localparam logic [7:0] PWM_TGT [4]   = '{8'd100, 8'd99, 8'd255, 8'd0};
  localparam int         PWM_HIGHS [4] = '{100, 100, 256, 0};
  localparam logic [3:0] PWM_EXP  = 4'b1001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] target_in = '0;
  logic          target_load = 1'b0;
  logic [CW-1:0] dac_code = '0;
  logic          pwm_in = 1'b0;
  logic          comp_r2r;
  logic          comp_pwm;
  logic          settled;
  logic          pwm_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] m_target   = '0;
  logic [CW-1:0] m_dac      = '0;
  logic          m_comp_r2r = 1'b0;
  logic          m_comp_pwm = 1'b0;

  always #5 clk = ~clk;

  sar_comparator_model #(
    .CODE_WIDTH     (CW),
    .SETTLE_CYCLES  (S),
    .PWM_WINDOW_LOG2(8)
  ) dut (
    .clk               (clk),
    .i_reset           (rst_n),
    .i_target_in       (target_in),
    .i_target_load     (target_load),
    .i_dac_code        (dac_code),
    .i_pwm_in          (pwm_in),
    .o_comp_r2r        (comp_r2r),
    .o_comp_pwm        (comp_pwm),
    .o_settled         (settled),
    .o_pwm_sample_valid(pwm_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; target_in = '0; target_load = 1'b0; dac_code = '0; pwm_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({comp_r2r, comp_pwm, settled, pwm_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b, expected 0000", k,
                 {comp_r2r, comp_pwm, settled, pwm_valid});
      end
    end
    rst_n = 1'b1;
    m_target = '0; m_dac = '0; m_comp_r2r = 1'b0; m_comp_pwm = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      tick();
      n_checks++;
      if (pwm_valid !== (k == WIN)) begin
        n_fail++;
        $display("FAIL first_valid clock %0d: got %b, expected %b", k, pwm_valid, (k == WIN));
      end
      n_checks++;
      if ({comp_r2r, settled} !== 2'b00) begin
        n_fail++;
        $display("FAIL r2r_idle_after_reset clock %0d: got %b, expected 00", k, {comp_r2r, settled});
      end
    end
    m_comp_pwm = 1'b1;
    n_checks++;
    if (comp_pwm !== m_comp_pwm) begin
      n_fail++;
      $display("FAIL first_comp_pwm: got %b, expected %b", comp_pwm, m_comp_pwm);
    end
    $display("reset: %0d checks so far", n_checks);
  endtask

  task automatic test_sar_sequence();
    m_target = 8'hD2;
    for (int i = 0; i < 8; i++) begin
      target_in = 8'hD2; target_load = (i == 0); dac_code = SAR_SEQ[i]; m_dac = SAR_SEQ[i];
      for (int k = 1; k <= HOLD; k++) begin
        tick();
        target_load = 1'b0;
        if (k > S) m_comp_r2r = (m_target >= m_dac);
        n_checks++;
        if (settled !== (k > S)) begin
          n_fail++;
          $display("FAIL sar_settled step %0d clock %0d: got %b, expected %b", i, k, settled, (k > S));
        end
        n_checks++;
        if (comp_r2r !== m_comp_r2r) begin
          n_fail++;
          $display("FAIL sar_comp step %0d clock %0d: got %b, expected %b", i, k, comp_r2r, m_comp_r2r);
        end
      end
      n_checks++;
      if (comp_r2r !== SAR_BITS[7-i]) begin
        n_fail++;
        $display("FAIL sar_bit step %0d dac %h: got %b, expected %b", i, SAR_SEQ[i], comp_r2r, SAR_BITS[7-i]);
      end
      $display("sar step %0d: target D2 dac %h -> comp_r2r %b", i, SAR_SEQ[i], comp_r2r);
    end
  endtask

  task automatic test_settle_restart();
    target_in = 8'h40; target_load = 1'b1; dac_code = 8'h10;
    m_target = 8'h40; m_dac = 8'h10;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      target_load = 1'b0;
      n_checks++;
      if ({settled, comp_r2r} !== {1'b0, m_comp_r2r}) begin
        n_fail++;
        $display("FAIL restart_first clock %0d: got %b, expected %b", k, {settled, comp_r2r}, {1'b0, m_comp_r2r});
      end
    end
    dac_code = 8'h30; m_dac = 8'h30;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (k > S) m_comp_r2r = (m_target >= m_dac);
      n_checks++;
      if ({settled, comp_r2r} !== {(k > S), m_comp_r2r}) begin
        n_fail++;
        $display("FAIL restart_second clock %0d: got %b, expected %b", k, {settled, comp_r2r}, {(k > S), m_comp_r2r});
      end
    end
    $display("settle restart: target 40 dac 30 -> comp_r2r %b", comp_r2r);
  endtask

  task automatic test_random_r2r();
    logic [CW-1:0] t;
    logic [CW-1:0] d;
    for (int i = 0; i < 2; i++) begin
      t = CW'($urandom_range(0, 255));
      d = CW'($urandom_range(0, 255));
      if (d == m_dac) d = d ^ 8'h01;
      target_in = t; target_load = 1'b1; dac_code = d;
      m_target = t; m_dac = d;
      for (int k = 1; k <= S + 10; k++) begin
        tick();
        target_load = 1'b0;
        if (k > S) m_comp_r2r = (m_target >= m_dac);
        n_checks++;
        if ({settled, comp_r2r} !== {(k > S), m_comp_r2r}) begin
          n_fail++;
          $display("FAIL random_r2r t %h d %h clock %0d: got %b, expected %b", t, d, k,
                   {settled, comp_r2r}, {(k > S), m_comp_r2r});
        end
      end
      $display("random r2r: target %h dac %h -> comp_r2r %b", t, d, comp_r2r);
    end
  endtask

  task automatic test_same_target_load();
    target_in = m_target; target_load = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      target_load = 1'b0;
      n_checks++;
      if ({settled, comp_r2r} !== {1'b1, m_comp_r2r}) begin
        n_fail++;
        $display("FAIL same_target_load clock %0d: got %b, expected %b", k, {settled, comp_r2r}, {1'b1, m_comp_r2r});
      end
    end
    $display("same target reload: settled %b comp_r2r %b", settled, comp_r2r);
  endtask

  task automatic test_pwm_duty();
    int waited = 0;
    while (pwm_valid !== 1'b1 && waited < WIN + 2) begin
      tick();
      waited++;
    end
    n_checks++;
    if (pwm_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pwm_align: got valid %b after %0d clocks, expected 1", pwm_valid, waited);
    end
    m_comp_pwm = comp_pwm;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < WIN; j++) begin
        pwm_in = (j < PWM_HIGHS[w]);
        if (j == 0) begin
          target_in = PWM_TGT[w]; target_load = 1'b1; m_target = PWM_TGT[w];
        end
        tick();
        target_load = 1'b0;
        if (j < WIN - 1) begin
          n_checks++;
          if ({pwm_valid, comp_pwm} !== {1'b0, m_comp_pwm}) begin
            n_fail++;
            $display("FAIL pwm_hold window %0d clock %0d: got %b, expected %b", w, j, {pwm_valid, comp_pwm}, {1'b0, m_comp_pwm});
          end
        end
      end
      m_comp_pwm = PWM_EXP[3-w];
      n_checks++;
      if ({pwm_valid, comp_pwm} !== {1'b1, m_comp_pwm}) begin
        n_fail++;
        $display("FAIL pwm_duty window %0d: got %b, expected %b", w, {pwm_valid, comp_pwm}, {1'b1, m_comp_pwm});
      end
      $display("pwm window: highs %0d target %0d -> comp_pwm %b", PWM_HIGHS[w], PWM_TGT[w], comp_pwm);
    end
  endtask

  task automatic test_pwm_random();
    int highs;
    int dens;
    for (int w = 0; w < 6; w++) begin
      highs = 0;
      dens  = $urandom_range(0, 256);
      for (int j = 0; j < WIN; j++) begin
        pwm_in = ($urandom_range(0, 255) < dens);
        if (pwm_in) highs++;
        if (j == 0) begin
          target_in = CW'($urandom_range(0, 255)); target_load = 1'b1; m_target = target_in;
        end
        tick();
        target_load = 1'b0;
        if (j < WIN - 1) begin
          n_checks++;
          if ({pwm_valid, comp_pwm} !== {1'b0, m_comp_pwm}) begin
            n_fail++;
            $display("FAIL pwm_rand_hold window %0d clock %0d: got %b, expected %b", w, j, {pwm_valid, comp_pwm}, {1'b0, m_comp_pwm});
          end
        end
      end
      m_comp_pwm = ({1'b0, m_target} >= 9'(highs));
      n_checks++;
      if ({pwm_valid, comp_pwm} !== {1'b1, m_comp_pwm}) begin
        n_fail++;
        $display("FAIL pwm_rand window %0d highs %0d target %0d: got %b, expected %b", w, highs, m_target,
                 {pwm_valid, comp_pwm}, {1'b1, m_comp_pwm});
      end
      $display("pwm random: highs %0d target %0d -> comp_pwm %b", highs, m_target, comp_pwm);
    end
  endtask

  task automatic test_reset_mid_settle();
    pwm_in = 1'b0;
    dac_code = m_dac ^ 8'h5A; m_dac = dac_code;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      n_checks++;
      if (settled !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_reset_settle clock %0d: got %b, expected 0", k, settled);
      end
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({comp_r2r, comp_pwm, settled, pwm_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_reset_outputs cycle %0d: got %b, expected 0000", k, {comp_r2r, comp_pwm, settled, pwm_valid});
      end
    end
    rst_n = 1'b1; target_in = 8'hFF; target_load = 1'b1; dac_code = 8'h00;
    m_target = 8'hFF; m_dac = 8'h00; m_comp_r2r = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      target_load = 1'b0;
      if (k > S) m_comp_r2r = (m_target >= m_dac);
      n_checks++;
      if ({settled, comp_r2r} !== {(k > S), m_comp_r2r}) begin
        n_fail++;
        $display("FAIL post_reset_r2r clock %0d: got %b, expected %b", k, {settled, comp_r2r}, {(k > S), m_comp_r2r});
      end
      n_checks++;
      if ({pwm_valid, comp_pwm} !== {(k % WIN == 0), (k >= WIN)}) begin
        n_fail++;
        $display("FAIL post_reset_pwm clock %0d: got %b, expected %b", k, {pwm_valid, comp_pwm}, {(k % WIN == 0), (k >= WIN)});
      end
    end
    $display("reset mid-settle: target FF dac 00 -> comp_r2r %b", comp_r2r);
  endtask

`ifdef SAR_COMPARATOR_MODEL_NOISE_EN
  task automatic test_noise();
    int ones;
    int zeros;
    target_in = 8'h80; target_load = 1'b1; dac_code = 8'h81;
    for (int k = 0; k < S + 2; k++) begin tick(); target_load = 1'b0; end
    ones = 0; zeros = 0;
    for (int k = 0; k < 1000; k++) begin tick(); if (comp_r2r) ones++; else zeros++; end
    n_checks++;
    if (ones == 0 || zeros == 0) begin
      n_fail++;
      $display("FAIL noise_toggle: got ones %0d zeros %0d, expected both nonzero", ones, zeros);
    end
    target_in = 8'hFF; target_load = 1'b1; dac_code = 8'hFF;
    for (int k = 0; k < S + 2; k++) begin tick(); target_load = 1'b0; end
    ones = 0; zeros = 0;
    for (int k = 0; k < 1000; k++) begin tick(); if (comp_r2r) ones++; else zeros++; end
    n_checks++;
    if (ones <= zeros) begin
      n_fail++;
      $display("FAIL noise_saturate: got ones %0d zeros %0d, expected ones to dominate", ones, zeros);
    end
    $display("noise: target FF dac FF ones %0d zeros %0d", ones, zeros);
  endtask
`endif

  initial begin
    test_reset();
    test_sar_sequence();
    test_settle_restart();
    test_random_r2r();
    test_same_target_load();
    test_pwm_duty();
    test_pwm_random();
    test_reset_mid_settle();
`ifdef SAR_COMPARATOR_MODEL_NOISE_EN
    test_noise();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
